exception_ctrl: RTL
===================

Name: exception_ctrl

Overview:
- MEM-stage exception/interrupt arbiter that sits directly upstream of the CP0 register file.
- Each cycle it collects the exception flags of the instruction in MEM and checks pending interrupts against the forwarded Status/Cause state.
- It drives excepttype, EPC source PC, delay-slot flag and bad address into CP0.
- It issues a registered one-cycle pipeline flush plus a redirect PC (exception vector, or EPC on ERET), and stalls commit while the data-memory access is still busy.

Parameters:
- EXC_VECTOR, 32'hBFC00380: redirect PC for every exception except ERET.
- IRQ_SYNC, 1: 1 = double-flop synchroniser on int_i before it enters the Cause.IP view; 0 = bypass.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- int_i  in  6  external hardware interrupt lines
- valid_i  in  1  MEM stage holds a real instruction (not a bubble)
- pc_i  in  32  PC of the MEM instruction
- in_delayslot_i  in  1  MEM instruction is in a branch delay slot
- adel_if_i  in  1  fetch address error
- ri_i  in  1  reserved instruction
- syscall_i  in  1  SYSCALL
- break_i  in  1  BREAK
- ov_i  in  1  arithmetic overflow
- trap_i  in  1  trap taken
- adel_mem_i  in  1  load address error
- ades_mem_i  in  1  store address error
- eret_i  in  1  ERET
- mem_addr_i  in  32  data address of the MEM instruction
- mem_busy_i  in  1  data-side access still outstanding
- cp0_status_i  in  32  CP0 Status
- cp0_cause_i  in  32  CP0 Cause
- cp0_epc_i  in  32  CP0 EPC
- wb_cp0_we_i  in  1  MTC0 write pending in WB
- wb_cp0_addr_i  in  5  MTC0 target register
- wb_cp0_data_i  in  32  MTC0 data
- excepttype_o  out  32  exception code to CP0; 0 = none
- epc_pc_o  out  32  PC handed to CP0 for EPC
- in_delayslot_o  out  1  delay-slot flag to CP0
- bad_addr_o  out  32  BadVAddr value to CP0
- stall_o  out  1  hold IF..MEM
- flush_o  out  1  flush IF..MEM (registered)
- new_pc_o  out  32  redirect target, valid while flush_o=1

Behaviour:
- **Forwarding.** If wb_cp0_we_i and wb_cp0_addr_i==12, effective Status = wb data, otherwise cp0_status_i. EPC (addr 14) is forwarded the same way. Cause forwarding covers only bits [9:8], on wb_cp0_addr_i==13.
- **Interrupt pending.** Effective Cause[15:10] is replaced by int_sync (the 2-flop synchronised int_i when IRQ_SYNC=1). Pending = Status[0] & ~Status[1] & |(Cause[15:8] & Status[15:8]).
- **Code selection.** Applies only when valid_i=1. Priority high to low, with the code emitted for each:
  - INT 0x1
  - AdEL fetch 0x4
  - RI 0xa
  - SYSCALL 0x8
  - BREAK 0x9
  - Ov 0xc
  - Trap 0xd
  - AdEL data 0x4
  - AdES 0x5
  - ERET 0xe
- **bad_addr_o.**
  - AdEL fetch: pc_i.
  - AdEL/AdES data: mem_addr_i.
  - Otherwise: 0.
- **State machine.** States IDLE, WAIT, FLUSH. Reset goes to IDLE.
- **IDLE.**
  - Code present and mem_busy_i=0: excepttype_o = code in the same cycle (combinational, CP0 commits on that edge); next state FLUSH.
  - Code present and mem_busy_i=1: stall_o=1, excepttype_o=0; latch the code, pc, delay-slot flag and bad addr; next state WAIT.
- **WAIT.**
  - stall_o=1 while mem_busy_i=1.
  - On the first cycle mem_busy_i=0: emit the latched code for exactly that cycle, using the latched values; next state FLUSH.
  - A newly pending interrupt does not replace the latched code.
- **FLUSH.**
  - flush_o=1 for exactly one cycle.
  - new_pc_o = forwarded EPC (captured at commit) if the code was 0xe, otherwise EXC_VECTOR.
  - excepttype_o is forced to 0 and valid_i is ignored.
  - Next state IDLE.
- **Back-to-back.** An exception in the cycle right after FLUSH is evaluated normally, so the minimum spacing between commits is 2 cycles.
- **Reset values.** All outputs 0, state IDLE, synchroniser flops 0.
- **Reset mid-WAIT/FLUSH.** Abandons the latched exception; no flush is issued.

Test Plan:
- Syscall at pc 0xBFC00100, mem_busy_i=0 → excepttype_o=0x8 and epc_pc_o=0xBFC00100 in cycle T; flush_o=1 with new_pc_o=0xBFC00380 in T+1 only.
- ri_i and ov_i together, with in_delayslot_i=1 → excepttype_o=0xa and in_delayslot_o=1.
- ERET while WB writes EPC=0x80001234 in the same cycle → new_pc_o=0x80001234, not the stale cp0_epc_i.
- Status=0x0000FF01, int_i[0]=1, IRQ_SYNC=1 → excepttype_o=0x1 on the second valid cycle after int_i rises. With Status[1]=1 → no exception.
- AdES at mem_addr 0x80000003 with mem_busy_i held 3 cycles → stall_o=1 for 3 cycles, then excepttype_o=0x5 and bad_addr_o=0x80000003, then flush_o.
- rst asserted during WAIT → flush_o stays 0, all outputs 0 the next cycle.

Source files
------------

// File: rtl/exception_ctrl_if.sv
// exception_ctrl_if: MEM-stage exception flags, CP0 state and commit/redirect signals.
interface exception_ctrl_if;
    logic [5:0]  int_i;
    logic        valid_i;
    logic [31:0] pc_i;
    logic        in_delayslot_i;
    logic        adel_if_i;
    logic        ri_i;
    logic        syscall_i;
    logic        break_i;
    logic        ov_i;
    logic        trap_i;
    logic        adel_mem_i;
    logic        ades_mem_i;
    logic        eret_i;
    logic [31:0] mem_addr_i;
    logic        mem_busy_i;
    logic [31:0] cp0_status_i;
    logic [31:0] cp0_cause_i;
    logic [31:0] cp0_epc_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_addr_i;
    logic [31:0] wb_cp0_data_i;
    logic [31:0] excepttype_o;
    logic [31:0] epc_pc_o;
    logic        in_delayslot_o;
    logic [31:0] bad_addr_o;
    logic        stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    modport master (
        output int_i, valid_i, pc_i, in_delayslot_i, adel_if_i, ri_i, syscall_i, break_i,
               ov_i, trap_i, adel_mem_i, ades_mem_i, eret_i, mem_addr_i, mem_busy_i,
               cp0_status_i, cp0_cause_i, cp0_epc_i, wb_cp0_we_i, wb_cp0_addr_i, wb_cp0_data_i,
        input  excepttype_o, epc_pc_o, in_delayslot_o, bad_addr_o, stall_o, flush_o, new_pc_o
    );
    modport slave (
        input  int_i, valid_i, pc_i, in_delayslot_i, adel_if_i, ri_i, syscall_i, break_i,
               ov_i, trap_i, adel_mem_i, ades_mem_i, eret_i, mem_addr_i, mem_busy_i,
               cp0_status_i, cp0_cause_i, cp0_epc_i, wb_cp0_we_i, wb_cp0_addr_i, wb_cp0_data_i,
        output excepttype_o, epc_pc_o, in_delayslot_o, bad_addr_o, stall_o, flush_o, new_pc_o
    );
endinterface

// File: rtl/exception_ctrl.sv
// exception_ctrl: MEM-stage exception/interrupt arbiter feeding CP0, with registered flush/redirect.
module exception_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter bit          IRQ_SYNC   = 1'b1
) (
    input logic             clk,
    input logic             rst,
    exception_ctrl_if.slave bus
);
    localparam logic [31:0] ERET_CODE = 32'h0000000e;
    typedef enum logic [1:0] {IDLE, WAIT, FLUSH} state_t;
    state_t      r_state, w_next;
    logic [5:0]  r_sync1, r_sync2, w_int;
    logic [31:0] w_status, w_epc_fwd, w_code, w_bad_sel;
    logic [1:0]  w_sw;
    logic        w_irq, w_sync_exc;
    logic [31:0] r_code, r_pc, r_bad, r_new_pc;
    logic        r_ds;
    logic [31:0] w_exc, w_epc_pc, w_bad;
    logic        w_ds, w_stall, w_commit;
    assign w_int      = IRQ_SYNC ? r_sync2 : bus.int_i;
    assign w_status   = (bus.wb_cp0_we_i && bus.wb_cp0_addr_i == 5'd12) ? bus.wb_cp0_data_i : bus.cp0_status_i;
    assign w_epc_fwd  = (bus.wb_cp0_we_i && bus.wb_cp0_addr_i == 5'd14) ? bus.wb_cp0_data_i : bus.cp0_epc_i;
    assign w_sw       = (bus.wb_cp0_we_i && bus.wb_cp0_addr_i == 5'd13) ? bus.wb_cp0_data_i[9:8] : bus.cp0_cause_i[9:8];
    assign w_irq      = w_status[0] & ~w_status[1] & |({w_int, w_sw} & w_status[15:8]);
    assign w_sync_exc = bus.ri_i | bus.syscall_i | bus.break_i | bus.ov_i | bus.trap_i;
    assign w_code = !bus.valid_i    ? 32'h0 :
                    w_irq           ? 32'h1 :
                    bus.adel_if_i   ? 32'h4 :
                    bus.ri_i        ? 32'ha :
                    bus.syscall_i   ? 32'h8 :
                    bus.break_i     ? 32'h9 :
                    bus.ov_i        ? 32'hc :
                    bus.trap_i      ? 32'hd :
                    bus.adel_mem_i  ? 32'h4 :
                    bus.ades_mem_i  ? 32'h5 :
                    bus.eret_i      ? ERET_CODE : 32'h0;
    // BadVAddr follows whichever source actually won the priority chain
    assign w_bad_sel = (!bus.valid_i || w_irq)            ? 32'h0 :
                       bus.adel_if_i                      ? bus.pc_i :
                       w_sync_exc                         ? 32'h0 :
                       (bus.adel_mem_i | bus.ades_mem_i)  ? bus.mem_addr_i : 32'h0;
    always_comb begin
        w_next   = r_state;
        w_exc    = '0;
        w_epc_pc = '0;
        w_ds     = 1'b0;
        w_bad    = '0;
        w_stall  = 1'b0;
        w_commit = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE: if (w_code != '0) begin
                    if (bus.mem_busy_i) begin
                        w_stall = 1'b1;
                        w_next  = WAIT;
                    end else begin
                        w_exc    = w_code;
                        w_epc_pc = bus.pc_i;
                        w_ds     = bus.in_delayslot_i;
                        w_bad    = w_bad_sel;
                        w_commit = 1'b1;
                        w_next   = FLUSH;
                    end
                end
                WAIT: if (bus.mem_busy_i) begin
                    w_stall = 1'b1;
                end else begin
                    w_exc    = r_code;
                    w_epc_pc = r_pc;
                    w_ds     = r_ds;
                    w_bad    = r_bad;
                    w_commit = 1'b1;
                    w_next   = FLUSH;
                end
                default: w_next = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_code   <= '0;
            r_pc     <= '0;
            r_ds     <= 1'b0;
            r_bad    <= '0;
            r_new_pc <= '0;
        end else begin
            r_state <= w_next;
            r_sync1 <= bus.int_i;
            r_sync2 <= r_sync1;
            if (r_state == IDLE && w_next == WAIT) begin
                r_code <= w_code;
                r_pc   <= bus.pc_i;
                r_ds   <= bus.in_delayslot_i;
                r_bad  <= w_bad_sel;
            end
            if (w_commit) r_new_pc <= (w_exc == ERET_CODE) ? w_epc_fwd : EXC_VECTOR;
        end
    end
    assign bus.excepttype_o   = w_exc;
    assign bus.epc_pc_o       = w_epc_pc;
    assign bus.in_delayslot_o = w_ds;
    assign bus.bad_addr_o     = w_bad;
    assign bus.stall_o        = w_stall;
    assign bus.flush_o        = (r_state == FLUSH);
    assign bus.new_pc_o       = (r_state == FLUSH) ? r_new_pc : 32'h0;
endmodule
